alu_arbiter: RTL and testbench

- Shares one combinational 8-bit ALU (ops: add, sub, mul, div, shifts, rotates, logic, compare) between two independent requesters.
- Round-robin arbitration; registers the winner's operands; drives the ALU for one cycle; returns the registered result with a valid/ready handshake.
- Adds divide-by-zero detection and carry qualification around the ALU.
- Sits between two client FSMs and the single shared ALU instance.

---
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one external 8-bit ALU between two requesters
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [SEL_W-1:0]  r0_sel,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [SEL_W-1:0]  r1_sel,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              busy
);

  localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_DIV = SEL_W'(3);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state, state_nxt;
  logic               last_grant;
  logic               owner;
  logic [DATA_W-1:0]  a_q, b_q, data_q;
  logic [SEL_W-1:0]   sel_q;
  logic               carry_q, err_q;
  logic               grant_vld, grant_id, accept, rsp_hs, div_zero;

  // With both pending, the requester that did not win last time goes first.
  always_comb begin
    grant_vld = r0_valid | r1_valid;
    grant_id  = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
    accept    = (state == IDLE) && grant_vld;
    rsp_hs    = (state == RESP) && rsp_ready[owner];
    div_zero  = (sel_q == OP_DIV) && (b_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    r0_ready  = accept && !grant_id;
    r1_ready  = accept && grant_id;
    busy      = (state != IDLE);
    rsp_valid = 2'b00;
    if (state == RESP) rsp_valid = owner ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        owner <= grant_id;
        a_q   <= grant_id ? r1_a   : r0_a;
        b_q   <= grant_id ? r1_b   : r0_b;
        sel_q <= grant_id ? r1_sel : r0_sel;
      end
      // Divide-by-zero overrides whatever the ALU returns.
      if (state == EXEC) begin
        data_q  <= div_zero ? {DATA_W{1'b1}} : alu_out;
        err_q   <= div_zero;
        carry_q <= (sel_q == OP_ADD) ? alu_carry : 1'b0;
      end
      if (rsp_hs) last_grant <= owner;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign rsp_data  = data_q;
  assign rsp_carry = carry_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed-vector bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_valid, r0_ready, r1_valid, r1_ready;
  logic [7:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0] r0_sel, r1_sel;
  logic [1:0] rsp_valid, rsp_ready;
  logic [7:0] rsp_data, alu_a, alu_b, alu_out;
  logic       rsp_carry, rsp_err, alu_carry, busy;
  logic [3:0] alu_sel;

  int n_vec  = 0;
  int n_miss = 0;

  alu_arbiter #(.DATA_W(8), .SEL_W(4)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sel(r0_sel),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sel(r1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared ALU; divide by zero deliberately returns 0.
  always_comb begin
    logic [8:0] sum;
    sum       = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = sum[8];
    case (alu_sel)
      4'b0000: alu_out = sum[7:0];
      4'b0001: alu_out = alu_a - alu_b;
      4'b0010: alu_out = alu_a * alu_b;
      4'b0011: alu_out = (alu_b == 8'h00) ? 8'h00 : alu_a / alu_b;
      4'b1000: alu_out = alu_a & alu_b;
      4'b1001: alu_out = alu_a | alu_b;
      default: alu_out = 8'h00;
    endcase
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full single-requester transaction with the response taken immediately.
  task automatic run_op(input int req, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] sel, input logic [7:0] exp_data,
                        input logic exp_carry, input logic exp_err);
    if (req == 0) begin r0_a = a; r0_b = b; r0_sel = sel; r0_valid = 1'b1; end
    else          begin r1_a = a; r1_b = b; r1_sel = sel; r1_valid = 1'b1; end
    #1;
    check_vec("op_ready", {r1_ready, r0_ready}, (req == 0) ? 2'b01 : 2'b10);
    tick();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    #1;
    check_vec("exec_busy", busy, 1'b1);
    check_vec("exec_alu_a", alu_a, a);
    check_vec("exec_rsp_valid", rsp_valid, 2'b00);
    tick();
    #1;
    check_vec("rsp_valid", rsp_valid, (req == 0) ? 2'b01 : 2'b10);
    check_vec("rsp_data", rsp_data, exp_data);
    check_vec("rsp_carry", rsp_carry, exp_carry);
    check_vec("rsp_err", rsp_err, exp_err);
    rsp_ready = 2'b11;
    tick();
    rsp_ready = 2'b00;
    #1;
    check_vec("done_rsp_valid", rsp_valid, 2'b00);
    check_vec("done_busy", busy, 1'b0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 2'b00;
    r0_a = 8'h00; r0_b = 8'h00; r0_sel = 4'h0;
    r1_a = 8'h00; r1_b = 8'h00; r1_sel = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_vec("rst_busy", busy, 1'b0);
    check_vec("rst_rsp_valid", rsp_valid, 2'b00);
    check_vec("rst_rsp_data", rsp_data, 8'h00);
    check_vec("rst_carry_err", {rsp_carry, rsp_err}, 2'b00);
    check_vec("rst_alu", {alu_a, alu_b, alu_sel}, 20'h0);
    check_vec("rst_ready", {r1_ready, r0_ready}, 2'b00);
    tick();

    run_op(0, 8'h0F, 8'h01, 4'b0000, 8'h10, 1'b0, 1'b0);
    run_op(1, 8'hFF, 8'h02, 4'b0000, 8'h01, 1'b1, 1'b0);
    run_op(1, 8'hFF, 8'h02, 4'b1000, 8'h02, 1'b0, 1'b0);

    // Both requesters streaming: grants alternate, one response every 3 cycles.
    r0_a = 8'h01; r0_b = 8'h01; r0_sel = 4'b0000;
    r1_a = 8'h03; r1_b = 8'h04; r1_sel = 4'b0000;
    r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 2'b11;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      check_vec("fair_r0_ready", r0_ready, (cyc % 6) == 0);
      check_vec("fair_r1_ready", r1_ready, (cyc % 6) == 3);
      check_vec("fair_rsp_valid", rsp_valid,
                ((cyc % 6) == 2) ? 2'b01 : (((cyc % 6) == 5) ? 2'b10 : 2'b00));
      if ((cyc % 6) == 2) check_vec("fair_data_r0", rsp_data, 8'h02);
      if ((cyc % 6) == 5) check_vec("fair_data_r1", rsp_data, 8'h07);
      tick();
    end
    r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 2'b00;
    tick();

    run_op(0, 8'h20, 8'h00, 4'b0011, 8'hFF, 1'b0, 1'b1);
    run_op(0, 8'h20, 8'h04, 4'b0011, 8'h08, 1'b0, 1'b0);

    // Backpressure: owner r0 withholds rsp_ready while the non-owner asserts it.
    r0_a = 8'h05; r0_b = 8'h03; r0_sel = 4'b0000; r0_valid = 1'b1;
    tick();
    r0_valid = 1'b0;
    tick();
    r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 2'b10;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      check_vec("bp_rsp_valid", rsp_valid, 2'b01);
      check_vec("bp_rsp_data", rsp_data, 8'h08);
      check_vec("bp_ready", {r1_ready, r0_ready}, 2'b00);
      tick();
    end
    r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    #1;
    check_vec("bp_release_valid", rsp_valid, 2'b00);
    check_vec("bp_release_busy", busy, 1'b0);

    // Reset while a response is pending discards it and restores r0 priority.
    r1_a = 8'h11; r1_b = 8'h22; r1_sel = 4'b1001; r1_valid = 1'b1;
    tick();
    r1_valid = 1'b0;
    tick();
    #1;
    check_vec("rr_pre_valid", rsp_valid, 2'b10);
    check_vec("rr_pre_data", rsp_data, 8'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_vec("rr_rsp_valid", rsp_valid, 2'b00);
    check_vec("rr_busy", busy, 1'b0);
    check_vec("rr_rsp_data", rsp_data, 8'h00);
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    check_vec("rr_first_grant", {r1_ready, r0_ready}, 2'b01);
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
